// File: rtl/sim_run_controller_if.sv
// Run/dump sequencer bus: control inputs, CPU reset, memory read port and dump/result outputs.
interface sim_run_controller_if #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned ADDR_LEN  = 5,
    parameter int unsigned CNT_W     = 16
);
    logic                 start;
    logic                 halt;
    logic [CNT_W-1:0]     run_limit;
    logic [WORD_SIZE-1:0] cmp_mask;
    logic                 cpu_rstn;
    logic                 mem_rd_en;
    logic [ADDR_LEN-1:0]  mem_rd_addr;
    logic [WORD_SIZE-1:0] mem_rd_data;
    logic [WORD_SIZE-1:0] exp_data;
    logic                 dump_valid;
    logic [ADDR_LEN-1:0]  dump_addr;
    logic [WORD_SIZE-1:0] dump_data;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 timeout;
    logic [CNT_W-1:0]     cycle_count;
    logic [ADDR_LEN:0]    err_count;
    logic [ADDR_LEN-1:0]  first_err_addr;

    // Controller side
    modport master (
        input  start, halt, run_limit, cmp_mask, mem_rd_data, exp_data,
        output cpu_rstn, mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data,
               busy, done, pass, timeout, cycle_count, err_count, first_err_addr
    );

    // CPU / memory / bench side
    modport slave (
        output start, halt, run_limit, cmp_mask, mem_rd_data, exp_data,
        input  cpu_rstn, mem_rd_en, mem_rd_addr, dump_valid, dump_addr, dump_data,
               busy, done, pass, timeout, cycle_count, err_count, first_err_addr
    );
endinterface

// File: rtl/sim_run_controller.sv
// Run/dump sequencer: holds the CPU in reset, runs it to halt or budget, then sweeps and
// compares data memory against an expected image.
module sim_run_controller #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDR_LEN     = 5,
    parameter int unsigned MEM_SIZE     = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned MAX_CYCLES   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    sim_run_controller_if.master bus
);
    localparam int unsigned ERR_W  = ADDR_LEN + 1;
    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_RUN, S_DUMP, S_DRAIN, S_DONE
    } state_t;

    state_t               state_q, state_n;
    logic [HOLD_W-1:0]    hold_q, hold_n;
    logic [CNT_W-1:0]     budget_q, budget_n;
    logic [WORD_SIZE-1:0] mask_q, mask_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 timeout_q, timeout_n;
    logic [ADDR_LEN-1:0]  addr_q, addr_n;
    logic [ERR_W-1:0]     err_q, err_n;
    logic [ADDR_LEN-1:0]  first_q, first_n;
    logic                 dv_q, dv_n;
    logic [ADDR_LEN-1:0]  daddr_q, daddr_n;
    logic                 rstn_q, rstn_n;
    logic                 rd_en_q, rd_en_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic                 pass_q, pass_n;
    logic                 mismatch_c;

    // Next-state, counters, compare and registered-output values
    always_comb begin
        state_n   = state_q;
        hold_n    = hold_q;
        budget_n  = budget_q;
        mask_n    = mask_q;
        cnt_n     = cnt_q;
        timeout_n = timeout_q;
        addr_n    = addr_q;
        err_n     = err_q;
        first_n   = first_q;
        mismatch_c = dv_q && (((bus.mem_rd_data ^ bus.exp_data) & mask_q) != '0);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_n   = S_HOLD;
                    hold_n    = '0;
                    budget_n  = (bus.run_limit == '0) ? CNT_W'(MAX_CYCLES) : bus.run_limit;
                    mask_n    = bus.cmp_mask;
                    cnt_n     = '0;
                    timeout_n = 1'b0;
                    addr_n    = '0;
                    err_n     = '0;
                    first_n   = '0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_n = S_RUN;
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            S_RUN: begin
                cnt_n = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                // Halt takes priority over the budget when both hit in one cycle
                if (bus.halt) begin
                    state_n = S_DUMP;
                    addr_n  = '0;
                end else if (CNT_W'(cnt_q + 1'b1) == budget_q) begin
                    state_n   = S_DUMP;
                    addr_n    = '0;
                    timeout_n = 1'b1;
                end
            end
            S_DUMP: begin
                if (addr_q == ADDR_LEN'(MEM_SIZE - 1)) begin
                    addr_n  = '0;
                    state_n = S_DRAIN;
                end else begin
                    addr_n = addr_q + 1'b1;
                end
            end
            S_DRAIN: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase

        // Beats only occur in DUMP/DRAIN, so this never collides with the start-time clear
        if (mismatch_c) begin
            err_n = err_q + 1'b1;
            if (err_q == '0) begin
                first_n = daddr_q;
            end
        end

        dv_n    = (state_q == S_DUMP);
        daddr_n = (state_q == S_DUMP) ? addr_q : '0;
        rstn_n  = (state_n == S_RUN);
        rd_en_n = (state_n == S_DUMP);
        busy_n  = state_n inside {S_HOLD, S_RUN, S_DUMP, S_DRAIN};
        done_n  = (state_n == S_DONE);
        pass_n  = done_n && (err_n == '0) && !timeout_n;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            budget_q  <= '0;
            mask_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            addr_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
            dv_q      <= 1'b0;
            daddr_q   <= '0;
            rstn_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            hold_q    <= hold_n;
            budget_q  <= budget_n;
            mask_q    <= mask_n;
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
            addr_q    <= addr_n;
            err_q     <= err_n;
            first_q   <= first_n;
            dv_q      <= dv_n;
            daddr_q   <= daddr_n;
            rstn_q    <= rstn_n;
            rd_en_q   <= rd_en_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            pass_q    <= pass_n;
        end
    end

    assign bus.cpu_rstn       = rstn_q;
    assign bus.mem_rd_en      = rd_en_q;
    assign bus.mem_rd_addr    = addr_q;
    assign bus.dump_valid     = dv_q;
    assign bus.dump_addr      = daddr_q;
    // Read data arrives in the beat cycle; gated so the stream is quiet between beats
    assign bus.dump_data      = dv_q ? bus.mem_rd_data : '0;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.timeout        = timeout_q;
    assign bus.cycle_count    = cnt_q;
    assign bus.err_count      = err_q;
    assign bus.first_err_addr = first_q;
endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: table of full run/dump cases on a default instance plus
// hand sequences for reset, mid-dump reset and a RESET_CYCLES=3 instance.
module tb_sim_run_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sim_run_controller_if #(.WORD_SIZE(32), .ADDR_LEN(5), .CNT_W(16)) bus0 ();
    sim_run_controller_if #(.WORD_SIZE(32), .ADDR_LEN(5), .CNT_W(16)) bus1 ();

    sim_run_controller #(
        .WORD_SIZE(32), .ADDR_LEN(5), .MEM_SIZE(32), .CNT_W(16), .RESET_CYCLES(1), .MAX_CYCLES(10)
    ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    sim_run_controller #(
        .WORD_SIZE(32), .ADDR_LEN(5), .MEM_SIZE(8), .CNT_W(16), .RESET_CYCLES(3), .MAX_CYCLES(10)
    ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic [31:0] mem0 [32];
    logic [31:0] exp0 [32];

    // One-cycle-latency memory and expected-image models
    always @(posedge clk) begin
        if (bus0.mem_rd_en) begin
            bus0.mem_rd_data <= mem0[bus0.mem_rd_addr];
            bus0.exp_data    <= exp0[bus0.mem_rd_addr];
        end
        if (bus1.mem_rd_en) begin
            bus1.mem_rd_data <= 32'hA5A5_0000 | 32'(bus1.mem_rd_addr);
            bus1.exp_data    <= 32'hA5A5_0000 | 32'(bus1.mem_rd_addr);
        end
    end

    typedef struct {
        int          halt_at;     // RUN cycle on which halt is raised, 0 = never
        logic [15:0] limit;
        logic [31:0] mask;
        int          bad_a;       // expected-image addresses corrupted, -1 = none
        int          bad_b;
        logic [31:0] flip;
        bit          start_in_run;
        int          exp_cc;
        bit          exp_to;
        int          exp_err;
        int          exp_first;
        bit          exp_pass;
    } vec_t;

    int cur = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s (case %0d): got %0d, expected %0d", name, cur, act, req);
        end
    endtask

    // Apply one table case to instance 0 and check the whole run/dump
    task automatic run_vec(input vec_t v);
        int run_cyc = 0, beats = 0, rd_cyc = 0, g = 0, last_beat_g = -1, done_g = -1;
        bit order_ok = 1'b1, frozen_ok = 1'b1, seen_done = 1'b0;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = (32'(i) * 32'h0001_0003) ^ 32'hC0DE_0000;
            exp0[i] = mem0[i];
            if (i == v.bad_a || i == v.bad_b) exp0[i] = exp0[i] ^ v.flip;
        end
        @(negedge clk);
        bus0.run_limit = v.limit;
        bus0.cmp_mask  = v.mask;
        bus0.start     = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check("start_clear", {bus0.busy, bus0.done, bus0.timeout, bus0.pass,
                              32'(bus0.err_count), 16'(bus0.cycle_count)}, 64'd0 | (64'd1 << 51));
        for (g = 0; g < 300 && !seen_done; g++) begin
            if (bus0.done) begin
                seen_done = 1'b1;
                done_g    = g;
            end else begin
                if (bus0.cpu_rstn) run_cyc++;
                bus0.halt  = bus0.cpu_rstn && (run_cyc == v.halt_at);
                bus0.start = v.start_in_run && bus0.cpu_rstn && (run_cyc == 3);
                if (bus0.mem_rd_en) begin
                    rd_cyc++;
                    if (bus0.cpu_rstn) frozen_ok = 1'b0;
                end
                if (bus0.dump_valid) begin
                    if (beats >= 32 || int'(bus0.dump_addr) != beats || bus0.dump_data !== mem0[beats])
                        order_ok = 1'b0;
                    beats++;
                    last_beat_g = g;
                end
                @(negedge clk);
            end
        end
        bus0.halt  = 1'b0;
        bus0.start = 1'b0;
        check("done_seen",   seen_done, 1);
        check("run_length",  run_cyc, v.exp_cc);
        check("cycle_count", bus0.cycle_count, v.exp_cc);
        check("timeout",     bus0.timeout, v.exp_to);
        check("err_count",   bus0.err_count, v.exp_err);
        check("first_err",   bus0.first_err_addr, v.exp_first);
        check("pass",        bus0.pass, v.exp_pass);
        check("busy_done",   bus0.busy, 0);
        check("read_cycles", rd_cyc, 32);
        check("dump_beats",  beats, 32);
        check("beat_order",  order_ok, 1);
        check("cpu_frozen",  frozen_ok, 1);
        check("done_timing", done_g, last_beat_g + 1);
    endtask

    // One run on the RESET_CYCLES=3 instance, halting on RUN cycle 2
    task automatic run_inst1();
        int hold = 0, run_cyc = 0, beats = 0, g = 0;
        bit data_ok = 1'b1, seen_done = 1'b0;
        @(negedge clk);
        bus1.run_limit = 16'd0;
        bus1.cmp_mask  = 32'hFFFF_FFFF;
        bus1.start     = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check("i1_done_clr", {bus1.done, bus1.busy}, 2'b01);
        for (g = 0; g < 100 && !seen_done; g++) begin
            if (bus1.done) begin
                seen_done = 1'b1;
            end else begin
                if (!bus1.cpu_rstn && bus1.busy && run_cyc == 0) hold++;
                if (bus1.cpu_rstn) run_cyc++;
                bus1.halt = bus1.cpu_rstn && (run_cyc == 2);
                if (bus1.dump_valid) begin
                    if (int'(bus1.dump_addr) != beats ||
                        bus1.dump_data !== (32'hA5A5_0000 | 32'(beats))) data_ok = 1'b0;
                    beats++;
                end
                @(negedge clk);
            end
        end
        bus1.halt = 1'b0;
        check("i1_done",   seen_done, 1);
        check("i1_hold",   hold, 3);
        check("i1_run",    bus1.cycle_count, 2);
        check("i1_beats",  beats, 8);
        check("i1_data",   data_ok, 1);
        check("i1_pass",   bus1.pass, 1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4, 16'd0, 32'hFFFF_FFFF, -1, -1, 32'h0,         0, 4,  0, 0, 0,  1};
        vecs[1] = '{0, 16'd0, 32'hFFFF_FFFF, -1, -1, 32'h0,         0, 10, 1, 0, 0,  0};
        vecs[2] = '{2, 16'd0, 32'hFFFF_FFFF,  3, 17, 32'h100,       0, 2,  0, 2, 3,  0};
        vecs[3] = '{2, 16'd0, 32'h0,          3, 17, 32'h100,       0, 2,  0, 0, 0,  1};
        vecs[4] = '{6, 16'd6, 32'hFFFF_FFFF, -1, -1, 32'h0,         1, 6,  0, 0, 0,  1};
        vecs[5] = '{0, 16'd6, 32'hFFFF_FFFF, -1, -1, 32'h0,         0, 6,  1, 0, 0,  0};
        vecs[6] = '{1, 16'd0, 32'hFFFF_FFFF,  0, 31, 32'h8000_0000, 0, 1,  0, 2, 0,  0};
        vecs[7] = '{0, 16'd1, 32'hFFFF_FEFF,  5,  9, 32'h100,       0, 1,  1, 0, 0,  0};
        vecs[8] = '{3, 16'd0, 32'h0000_00FF, 20, -1, 32'h1,         0, 3,  0, 1, 20, 0};

        bus0.start = 1'b0; bus0.halt = 1'b0; bus0.run_limit = '0; bus0.cmp_mask = '0;
        bus1.start = 1'b0; bus1.halt = 1'b0; bus1.run_limit = '0; bus1.cmp_mask = '0;
        bus0.mem_rd_data = '0; bus0.exp_data = '0;
        bus1.mem_rd_data = '0; bus1.exp_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_rstn", bus0.cpu_rstn, 0);
        check("rst_outputs", {bus0.mem_rd_en, bus0.dump_valid, bus0.busy, bus0.done, bus0.pass,
                              bus0.timeout}, 0);
        check("rst_counts", {16'(bus0.cycle_count), 6'(bus0.err_count), 5'(bus0.first_err_addr),
                             5'(bus0.mem_rd_addr), 5'(bus0.dump_addr)}, 0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            cur = k;
            run_vec(vecs[k]);
        end

        // Reset pulse while the sweep is at address 9
        cur = 100;
        for (int i = 0; i < 32; i++) begin
            mem0[i] = 32'(i) + 32'h5000;
            exp0[i] = mem0[i];
        end
        @(negedge clk);
        bus0.run_limit = 16'd0;
        bus0.cmp_mask  = 32'hFFFF_FFFF;
        bus0.start     = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        begin
            int g = 0;
            int rc = 0;
            while (g < 100 && !(bus0.mem_rd_en && bus0.mem_rd_addr == 5'd9)) begin
                if (bus0.cpu_rstn) rc++;
                bus0.halt = bus0.cpu_rstn && (rc == 1);
                @(negedge clk);
                g++;
            end
            bus0.halt = 1'b0;
            check("reach_addr9", g < 100, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_stream", {bus0.dump_valid, bus0.mem_rd_en, bus0.busy, bus0.done}, 0);
        check("mid_rst_cpu",    bus0.cpu_rstn, 0);
        check("mid_rst_counts", {16'(bus0.cycle_count), 6'(bus0.err_count)}, 0);
        rst = 1'b0;
        begin
            int late = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus0.dump_valid || bus0.busy) late++;
            end
            check("no_late_beats", late, 0);
        end

        // RESET_CYCLES=3 instance: first run from IDLE, second from DONE
        cur = 200;
        run_inst1();
        cur = 201;
        run_inst1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
